// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit asynchronous SRAM between three requesters.
// The requesters are the frame-buffer reader, the 32-bit scene loader and the
// 16-bit pixel writer. Every access takes two cycles. Reads have priority,
// with a starvation guard so that a pending write is eventually forced
// through. The two writers share the remaining slots round-robin.
// Optional build macro: ARB_STATS_EN adds 16-bit saturating grant counters.
module sram_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        rd_req,
    input  logic [19:0] rd_addr,
    output logic        rd_gnt,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        sl_we,
    input  logic [24:0] sl_addr,
    input  logic [31:0] sl_io,
    output logic        sl_ack,
    input  logic        fb_we,
    input  logic [19:0] fb_addr,
    input  logic [15:0] fb_data,
    output logic        fb_ack,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_b,
    output logic        sram_oe_b,
    output logic        sram_ce_b,
    output logic        sram_ub_b,
    output logic        sram_lb_b
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_sl,
    output logic [15:0] stat_fb
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_RD2  = 3'd2;
    localparam logic [2:0] S_WR1  = 3'd3;
    localparam logic [2:0] S_WR2  = 3'd4;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [2:0]       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             last_sl;     // last write granted went to the scene loader
    logic             cur_is_sl;   // write in flight belongs to the scene loader
    logic             sl_hi;       // scene-loader access in flight is the high half
    logic [19:0]      addr_p0;
    logic [15:0]      wdata_p0;
    logic [15:0]      hi_p0;       // high half of sl_io parked for the second access

    logic arb_en, in_ack, sl_lock, sl_pend, fb_pend, wr_pend;
    logic starved, win_rd, win_wr, pick_sl;

    // The upper scene-loader address bits select nothing in this SRAM.
    logic unused_sl_addr;
    assign unused_sl_addr = ^sl_addr[24:19];

    function automatic logic [CNT_W-1:0] sat_inc_starve(input logic [CNT_W-1:0] v);
        return (v == LIMIT_C) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Arbitration: the low half of a scene-loader write is never followed by arbitration.
    assign sl_lock = (state == S_WR2) && cur_is_sl && !sl_hi;
    assign arb_en  = (state == S_IDLE) || (state == S_RD2) || ((state == S_WR2) && !sl_lock);
    assign in_ack  = (state == S_WR2) && !sl_lock;
    // The writer being acknowledged still holds its request this cycle; it is not a new one.
    assign sl_pend = sl_we && !(in_ack && cur_is_sl);
    assign fb_pend = fb_we && !(in_ack && !cur_is_sl);
    assign wr_pend = sl_pend || fb_pend;
    assign starved = (starve_cnt == LIMIT_C);
    assign win_rd  = arb_en && rd_req && !(starved && wr_pend);
    assign win_wr  = arb_en && !win_rd && wr_pend;
    assign pick_sl = sl_pend && (!fb_pend || !last_sl);

    // Access sequencer and write ownership tracking.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= S_IDLE;
            last_sl   <= 1'b0;
            cur_is_sl <= 1'b0;
            sl_hi     <= 1'b0;
        end else begin
            case (state)
                S_RD1:   state <= S_RD2;
                S_WR1:   state <= S_WR2;
                default: begin
                    if (sl_lock) begin
                        state <= S_WR1;
                        sl_hi <= 1'b1;
                    end else if (win_rd) begin
                        state <= S_RD1;
                    end else if (win_wr) begin
                        state     <= S_WR1;
                        cur_is_sl <= pick_sl;
                        last_sl   <= pick_sl;
                        sl_hi     <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Starvation counter: reads beating a pending write, cleared by any write grant.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            starve_cnt <= '0;
        end else if (win_wr) begin
            starve_cnt <= '0;
        end else if (win_rd && wr_pend) begin
            starve_cnt <= sat_inc_starve(starve_cnt);
        end
    end

    // Address/data capture at grant; the locked high half reuses the parked word.
    always_ff @(posedge clk) begin
        if (win_rd) begin
            addr_p0 <= rd_addr;
        end else if (win_wr) begin
            if (pick_sl) begin
                addr_p0  <= {sl_addr[18:0], 1'b0};
                wdata_p0 <= sl_io[15:0];
                hi_p0    <= sl_io[31:16];
            end else begin
                addr_p0  <= fb_addr;
                wdata_p0 <= fb_data;
            end
        end else if (sl_lock) begin
            addr_p0[0] <= 1'b1;
            wdata_p0   <= hi_p0;
        end
    end

    // Read return: capture the SRAM bus at the end of RD2.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rd_valid <= 1'b0;
            rd_data  <= 16'd0;
        end else begin
            rd_valid <= (state == S_RD2);
            if (state == S_RD2) begin
                rd_data <= sram_dq_in;
            end
        end
    end

    // SRAM pin and handshake decode from the current state.
    always_comb begin
        sram_ce_b   = 1'b1;
        sram_oe_b   = 1'b1;
        sram_we_b   = 1'b1;
        sram_ub_b   = 1'b1;
        sram_lb_b   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_addr   = 20'd0;
        sram_dq_out = 16'd0;
        rd_gnt      = 1'b0;
        sl_ack      = 1'b0;
        fb_ack      = 1'b0;
        case (state)
            S_RD1, S_RD2: begin
                sram_ce_b = 1'b0;
                sram_oe_b = 1'b0;
                sram_ub_b = 1'b0;
                sram_lb_b = 1'b0;
                sram_addr = addr_p0;
                rd_gnt    = (state == S_RD1);
            end
            S_WR1, S_WR2: begin
                sram_ce_b   = 1'b0;
                sram_we_b   = (state == S_WR2);
                sram_ub_b   = 1'b0;
                sram_lb_b   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_addr   = addr_p0;
                sram_dq_out = wdata_p0;
                sl_ack      = (state == S_WR2) && cur_is_sl && sl_hi;
                fb_ack      = (state == S_WR2) && !cur_is_sl;
            end
            default: ;
        endcase
    end

`ifdef ARB_STATS_EN
    // Grant counters; a scene-loader write counts once at its first grant.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            stat_rd <= 16'd0;
            stat_sl <= 16'd0;
            stat_fb <= 16'd0;
        end else begin
            if (win_rd)             stat_rd <= sat_inc16(stat_rd);
            if (win_wr && pick_sl)  stat_sl <= sat_inc16(stat_sl);
            if (win_wr && !pick_sl) stat_fb <= sat_inc16(stat_fb);
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a tiny SRAM read model
// and a log of every write strobe seen on the SRAM pins.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        rd_req = 1'b0;
    logic [19:0] rd_addr = '0;
    logic        rd_gnt;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        sl_we = 1'b0;
    logic [24:0] sl_addr = '0;
    logic [31:0] sl_io = '0;
    logic        sl_ack;
    logic        fb_we = 1'b0;
    logic [19:0] fb_addr = '0;
    logic [15:0] fb_data = '0;
    logic        fb_ack;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe, sram_we_b, sram_oe_b, sram_ce_b, sram_ub_b, sram_lb_b;
`ifdef ARB_STATS_EN
    logic [15:0] stat_rd, stat_sl, stat_fb;
`endif

    int total = 0;
    int bad = 0;
    logic [19:0] wl_addr[$];
    logic [15:0] wl_data[$];

    sram_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_b(rst_b),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
        .sl_we(sl_we), .sl_addr(sl_addr), .sl_io(sl_io), .sl_ack(sl_ack),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ack(fb_ack),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_b(sram_we_b), .sram_oe_b(sram_oe_b),
        .sram_ce_b(sram_ce_b), .sram_ub_b(sram_ub_b), .sram_lb_b(sram_lb_b)
`ifdef ARB_STATS_EN
        , .stat_rd(stat_rd), .stat_sl(stat_sl), .stat_fb(stat_fb)
`endif
    );

    always #5 clk = ~clk;

    // SRAM read model: one known word, everything else a simple address pattern.
    always_comb begin
        sram_dq_in = (sram_addr == 20'h00010) ? 16'hBEEF : (sram_addr[15:0] ^ 16'h5A5A);
    end

    // Write strobe log, sampled mid-cycle.
    always @(negedge clk) begin
        if (!sram_we_b && !sram_ce_b) begin
            wl_addr.push_back(sram_addr);
            wl_data.push_back(sram_dq_out);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        wl_addr.delete();
        wl_data.delete();
    endtask

    task automatic test_reset;
        logic [5:0] ctl;
        rst_b = 1'b0;
        step;
        step;
        ctl = {sram_ce_b, sram_oe_b, sram_we_b, sram_ub_b, sram_lb_b, sram_dq_oe};
        total++;
        if (ctl !== 6'b111110) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, 6'b111110); end
        total++;
        if (sram_addr !== 20'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", sram_addr); end
        total++;
        if ({rd_gnt, rd_valid, sl_ack, fb_ack} !== 4'b0000) begin
            bad++; $display("FAIL reset_pulses got=%b want=0000", {rd_gnt, rd_valid, sl_ack, fb_ack});
        end
        total++;
        if (rd_data !== 16'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
        rst_b = 1'b1;
        step;
    endtask

    task automatic test_single_read;
        logic [5:0] ctl;
        rd_req = 1'b1;
        rd_addr = 20'h00010;
        step;
        total++;
        if (rd_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt_c1 got=%b want=1", rd_gnt); end
        total++;
        if (sram_addr !== 20'h00010) begin bad++; $display("FAIL rd_addr_c1 got=%h want=00010", sram_addr); end
        ctl = {sram_ce_b, sram_oe_b, sram_we_b, sram_ub_b, sram_lb_b, sram_dq_oe};
        total++;
        if (ctl !== 6'b001000) begin bad++; $display("FAIL rd_ctl got=%b want=%b", ctl, 6'b001000); end
        rd_req = 1'b0;
        step;
        total++;
        if ({rd_gnt, rd_valid} !== 2'b00) begin bad++; $display("FAIL rd_c2 got=%b want=00", {rd_gnt, rd_valid}); end
        step;
        total++;
        if (rd_valid !== 1'b1) begin bad++; $display("FAIL rd_valid_c3 got=%b want=1", rd_valid); end
        total++;
        if (rd_data !== 16'hBEEF) begin bad++; $display("FAIL rd_data_c3 got=%h want=beef", rd_data); end
        step;
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_c4 got=%b want=0", rd_valid); end
    endtask

    task automatic test_sl_write;
        int acks = 0;
        int ack_cyc = 0;
        logic [5:0] ctl;
        clear_log();
        sl_we = 1'b1;
        sl_addr = 25'h5;
        sl_io = 32'hDEADBEEF;
        for (int c = 1; c <= 6; c++) begin
            step;
            ctl = {sram_ce_b, sram_oe_b, sram_we_b, sram_ub_b, sram_lb_b, sram_dq_oe};
            if (sl_ack) begin acks++; ack_cyc = c; sl_we = 1'b0; end
            if (c == 1) begin
                total++;
                if (ctl !== 6'b010001) begin bad++; $display("FAIL sl_wr1_ctl got=%b want=%b", ctl, 6'b010001); end
                total++;
                if ({sram_addr, sram_dq_out} !== {20'h0000A, 16'hBEEF}) begin
                    bad++; $display("FAIL sl_wr1_bus got=%h/%h want=0000a/beef", sram_addr, sram_dq_out);
                end
            end
            if (c == 2) begin
                total++;
                if (ctl !== 6'b011001) begin bad++; $display("FAIL sl_wr2_ctl got=%b want=%b", ctl, 6'b011001); end
            end
            if (c == 3) begin
                total++;
                if ({sram_addr, sram_dq_out} !== {20'h0000B, 16'hDEAD}) begin
                    bad++; $display("FAIL sl_hi_bus got=%h/%h want=0000b/dead", sram_addr, sram_dq_out);
                end
            end
        end
        total++;
        if (acks != 1 || ack_cyc != 4) begin bad++; $display("FAIL sl_ack got=%0d@%0d want=1@4", acks, ack_cyc); end
        total++;
        if (wl_addr.size() != 2) begin
            bad++; $display("FAIL sl_log_size got=%0d want=2", wl_addr.size());
        end else if ({wl_addr[0], wl_data[0], wl_addr[1], wl_data[1]} !== {20'h0000A, 16'hBEEF, 20'h0000B, 16'hDEAD}) begin
            bad++; $display("FAIL sl_log got=%h:%h %h:%h want=0000a:beef 0000b:dead",
                            wl_addr[0], wl_data[0], wl_addr[1], wl_data[1]);
        end
    endtask

    task automatic test_fb_write;
        int acks = 0;
        int ack_cyc = 0;
        clear_log();
        fb_we = 1'b1;
        fb_addr = 20'h12345;
        fb_data = 16'h1234;
        for (int c = 1; c <= 4; c++) begin
            step;
            if (fb_ack) begin acks++; ack_cyc = c; fb_we = 1'b0; end
        end
        total++;
        if (acks != 1 || ack_cyc != 2) begin bad++; $display("FAIL fb_ack got=%0d@%0d want=1@2", acks, ack_cyc); end
        total++;
        if (wl_addr.size() != 1 || wl_addr[0] !== 20'h12345 || wl_data[0] !== 16'h1234) begin
            bad++; $display("FAIL fb_log size=%0d want one write 12345:1234", wl_addr.size());
        end
    endtask

    task automatic test_starvation;
        logic [7:0] seq[$];
        int first_w = -1;
        int n_w = 0;
        clear_log();
        rd_req = 1'b1;
        rd_addr = 20'h00100;
        fb_we = 1'b1;
        fb_addr = 20'h00777;
        fb_data = 16'hCAFE;
        for (int c = 1; c <= 24; c++) begin
            step;
            if (rd_gnt) seq.push_back("R");
            if (!sram_we_b) seq.push_back("W");
            if (fb_ack) fb_we = 1'b0;
        end
        rd_req = 1'b0;
        step; step; step;
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == "W") begin
                n_w++;
                if (first_w < 0) first_w = i;
            end
        end
        total++;
        if (seq.size() != 12) begin bad++; $display("FAIL starve_grants got=%0d want=12", seq.size()); end
        total++;
        if (first_w != 8 || n_w != 1) begin bad++; $display("FAIL starve_order got=w@%0d x%0d want=w@8 x1", first_w, n_w); end
        total++;
        if (seq.size() < 10 || seq[9] != "R") begin bad++; $display("FAIL starve_resume got=not_read want=read after write"); end
        total++;
        if (wl_addr.size() != 1 || wl_data[0] !== 16'hCAFE) begin
            bad++; $display("FAIL starve_log size=%0d want one write of cafe", wl_addr.size());
        end
    endtask

    task automatic test_round_robin;
        int order[$];
        clear_log();
        sl_we = 1'b1;
        sl_addr = 25'h1FFFFFF;
        sl_io = 32'hAAAA5555;
        fb_we = 1'b1;
        fb_addr = 20'h00042;
        fb_data = 16'h0F0F;
        for (int c = 1; c <= 12; c++) begin
            step;
            if (sl_ack) order.push_back(1);
            if (fb_ack) order.push_back(2);
        end
        sl_we = 1'b0;
        fb_we = 1'b0;
        step; step;
        total++;
        if (order.size() != 4) begin
            bad++; $display("FAIL rr_count got=%0d want=4", order.size());
        end else if (order[0] != 1 || order[1] != 2 || order[2] != 1 || order[3] != 2) begin
            bad++; $display("FAIL rr_order got=%0d%0d%0d%0d want=1212", order[0], order[1], order[2], order[3]);
        end
        total++;
        if (wl_addr.size() != 6 || wl_addr[0] !== 20'hFFFFE || wl_addr[1] !== 20'hFFFFF
            || wl_data[1] !== 16'hAAAA || wl_addr[2] !== 20'h00042) begin
            bad++; $display("FAIL rr_log size=%0d first=%h want=6 starting fffffe,fffff,00042",
                            wl_addr.size(), (wl_addr.size() > 0) ? wl_addr[0] : 20'h0);
        end
    endtask

    task automatic test_simultaneous;
        int g = 0;
        rst_b = 1'b0;
        step;
        rst_b = 1'b1;
        clear_log();
        rd_req = 1'b1;
        rd_addr = 20'h00020;
        sl_we = 1'b1;
        sl_addr = 25'h9;
        sl_io = 32'h01020304;
        fb_we = 1'b1;
        fb_addr = 20'h00099;
        fb_data = 16'h7777;
        for (int c = 1; c <= 10; c++) begin
            step;
            if (rd_gnt) begin g = c; rd_req = 1'b0; end
            if (sl_ack) sl_we = 1'b0;
            if (fb_ack) fb_we = 1'b0;
        end
        total++;
        if (g != 1) begin bad++; $display("FAIL simul_rd_first got=%0d want=1", g); end
        total++;
        if (wl_addr.size() != 3 || wl_addr[0] !== 20'h00012 || wl_data[1] !== 16'h0102 || wl_addr[2] !== 20'h00099) begin
            bad++; $display("FAIL simul_writes size=%0d want sl 00012/00013 then fb 00099", wl_addr.size());
        end
    endtask

    task automatic test_reset_mid_access;
        int acks = 0;
        logic [5:0] ctl;
        clear_log();
        sl_we = 1'b1;
        sl_addr = 25'h3;
        sl_io = 32'h11112222;
        step;
        total++;
        if (sram_we_b !== 1'b0) begin bad++; $display("FAIL abort_in_wr1 got=%b want=0", sram_we_b); end
        rst_b = 1'b0;
        sl_we = 1'b0;
        step;
        ctl = {sram_ce_b, sram_oe_b, sram_we_b, sram_ub_b, sram_lb_b, sram_dq_oe};
        total++;
        if (ctl !== 6'b111110 || sram_addr !== 20'h0) begin
            bad++; $display("FAIL abort_idle got=%b/%h want=111110/0", ctl, sram_addr);
        end
        rst_b = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step;
            if (sl_ack) acks++;
        end
        total++;
        if (acks != 0) begin bad++; $display("FAIL abort_ack got=%0d want=0", acks); end
        total++;
        if (wl_addr.size() != 1 || wl_addr[0] !== 20'h00006) begin
            bad++; $display("FAIL abort_high_half got=%0d writes want=1 (low half only)", wl_addr.size());
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats;
        int n = 0;
        int k = 0;
        rst_b = 1'b0;
        step;
        rst_b = 1'b1;
        total++;
        if ({stat_rd, stat_sl, stat_fb} !== 48'h0) begin bad++; $display("FAIL stats_reset got=%h want=0", {stat_rd, stat_sl, stat_fb}); end
        rd_req = 1'b1;
        rd_addr = 20'h00030;
        for (int c = 1; c <= 6; c++) begin
            step;
            if (rd_gnt) n++;
            if (n == 3) rd_req = 1'b0;
        end
        fb_we = 1'b1;
        fb_addr = 20'h00055;
        fb_data = 16'h5555;
        for (int c = 1; c <= 8; c++) begin
            step;
            if (fb_ack) begin k++; if (k == 2) fb_we = 1'b0; end
        end
        step; step;
        total++;
        if ({stat_rd, stat_fb, stat_sl} !== {16'd3, 16'd2, 16'd0}) begin
            bad++; $display("FAIL stats got=rd%0d fb%0d sl%0d want=rd3 fb2 sl0", stat_rd, stat_fb, stat_sl);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_sl_write();
        test_fb_write();
        test_starvation();
        test_round_robin();
        test_simultaneous();
        test_reset_mid_access();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
